// File: rtl/fp16_int_serial_multiplier_pkg.sv
// Shared constants and helpers for the FP16 x serial-integer-weight multiplier.
package fp16_int_serial_multiplier_pkg;

    // FP16 field layout
    localparam int SIGN_BIT   = 15;
    localparam int EXP_MSB    = 14;
    localparam int EXP_LSB    = 10;
    localparam int EXP_W      = EXP_MSB - EXP_LSB + 1;
    localparam int FRAC_W     = 10;

    // Significand including the hidden bit
    localparam int MANT_W     = FRAC_W + 1;

    // Product magnitude width: |-8 x 2047| = 16376 fits in 14 bits
    localparam int OUT_MANT_W = 14;

    // Weight precision: 1..MAX_PREC bits, held in a 3-bit register
    localparam int MAX_PREC   = 4;
    localparam int PREC_W     = 3;
    localparam int CNT_W      = 2;

    // Signed partial product width
    localparam int R_W        = 16;

    // Hidden bit is clear for zero/subnormal exponents.
    function automatic logic [MANT_W-1:0] significand(input logic [EXP_W-1:0]  e,
                                                      input logic [FRAC_W-1:0] f);
        return {|e, f};
    endfunction

    // Map an incoming precision request onto the legal 1..MAX_PREC range.
    function automatic logic [PREC_W-1:0] legal_prec(input logic [3:0] p);
        if (p >= 4'd1 && p <= 4'(MAX_PREC))
            return p[PREC_W-1:0];
        return PREC_W'(MAX_PREC);
    endfunction

endpackage

// File: rtl/fp16_int_serial_multiplier_serial_shift_add.sv
// Bit-serial shift-add datapath. Accumulates M << idx per set weight bit and
// subtracts on the weight's sign bit. Output r is the partial product after
// the bit currently presented, so the caller can capture the final product on
// the same edge that samples the last bit.
module serial_shift_add
    import fp16_int_serial_multiplier_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MANT_W-1:0]      m,
    input  logic                   w,
    input  logic [CNT_W-1:0]       idx,
    input  logic                   last,
    input  logic                   clear,
    input  logic                   flush,
    output logic signed [R_W-1:0]  r
);

    logic signed [R_W-1:0] r_q;
    logic signed [R_W-1:0] base;
    logic signed [R_W-1:0] addend;

    // Next partial product: bit 0 starts from zero, the sign bit carries negative weight.
    always_comb begin
        base   = clear ? '0 : r_q;
        addend = w ? (R_W'(m) << idx) : '0;
        r      = last ? (base - addend) : (base + addend);
    end

    // Partial product register; an aborted weight leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst || flush)
            r_q <= '0;
        else
            r_q <= r;
    end

endmodule

// File: rtl/fp16_int_serial_multiplier.sv
// FP16 activation x bit-serial two's-complement weight (1..4 bits, LSB first).
// Produces an unnormalised sign / biased exponent / integer magnitude product
// with a one-cycle start_acc strobe for the downstream accumulator.
module fp16_int_serial_multiplier
    import fp16_int_serial_multiplier_pkg::*;
#(
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACT_WIDTH-1:0]  act,
    input  logic                  w,
    input  logic                  valid,
    input  logic                  set,
    input  logic [3:0]            precision,
    output logic                  sign_out,
    output logic [EXP_W-1:0]      exp_out,
    output logic [OUT_MANT_W-1:0] mantissa_out,
    output logic                  start_acc
);

    // ACC_WIDTH only travels with the block for integration; an accumulator
    // narrower than the magnitude would be an integration error upstream.
    if (ACC_WIDTH < OUT_MANT_W) begin : g_acc_narrow
    end

    logic [PREC_W-1:0]     prec_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  lat_sign_q;
    logic [EXP_W-1:0]      lat_exp_q;
    logic [MANT_W-1:0]     lat_m_q;

    logic                  accept;
    logic                  abort;
    logic                  first;
    logic                  last;
    logic                  cur_sign;
    logic [EXP_W-1:0]      cur_exp;
    logic [MANT_W-1:0]     cur_m;
    logic signed [R_W-1:0] r_next;
    logic [OUT_MANT_W-1:0] mag_next;

    // Control decode. On bit 0 the activation is used straight from the port
    // (it is being latched on this same edge); later bits use the latched copy.
    always_comb begin
        accept   = valid && !set;
        abort    = !accept;
        first    = (cnt_q == '0);
        last     = ({1'b0, cnt_q} == (prec_q - 3'd1));
        cur_sign = first ? act[SIGN_BIT] : lat_sign_q;
        cur_exp  = first ? act[EXP_MSB:EXP_LSB] : lat_exp_q;
        cur_m    = first ? significand(act[EXP_MSB:EXP_LSB], act[FRAC_W-1:0]) : lat_m_q;
        mag_next = r_next[R_W-1] ? OUT_MANT_W'(-r_next) : r_next[OUT_MANT_W-1:0];
    end

    // Precision register; illegal requests fall back to the widest weight.
    always_ff @(posedge clk) begin
        if (rst)
            prec_q <= PREC_W'(MAX_PREC);
        else if (set)
            prec_q <= legal_prec(precision);
    end

    // Bit counter: wraps after the sign bit, restarts on abort or set.
    always_ff @(posedge clk) begin
        if (rst || abort)
            cnt_q <= '0;
        else if (last)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    // Capture the activation fields on the first bit of each weight.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_sign_q <= 1'b0;
            lat_exp_q  <= '0;
            lat_m_q    <= '0;
        end else if (accept && first) begin
            lat_sign_q <= act[SIGN_BIT];
            lat_exp_q  <= act[EXP_MSB:EXP_LSB];
            lat_m_q    <= significand(act[EXP_MSB:EXP_LSB], act[FRAC_W-1:0]);
        end
    end

    serial_shift_add u_datapath (
        .clk   (clk),
        .rst   (rst),
        .m     (cur_m),
        .w     (w),
        .idx   (cnt_q),
        .last  (last),
        .clear (first),
        .flush (abort),
        .r     (r_next)
    );

    // Result registers: update only on a completed weight, otherwise hold.
    // Sign follows the weight sign bit even for a zero magnitude.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_out     <= 1'b0;
            exp_out      <= '0;
            mantissa_out <= '0;
            start_acc    <= 1'b0;
        end else begin
            start_acc <= accept && last;
            if (accept && last) begin
                sign_out     <= cur_sign ^ w;
                exp_out      <= cur_exp;
                mantissa_out <= mag_next;
            end
        end
    end

endmodule

// File: tb/tb_fp16_int_serial_multiplier.sv
// Bench for fp16_int_serial_multiplier: table vectors, corner sequences and a
// random sweep, all checked through a scoreboard popped on start_acc.
module tb_fp16_int_serial_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] act;
    logic        w;
    logic        valid;
    logic        set;
    logic [3:0]  precision;
    logic        sign_out;
    logic [4:0]  exp_out;
    logic [13:0] mantissa_out;
    logic        start_acc;

    fp16_int_serial_multiplier #(.ACT_WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .act          (act),
        .w            (w),
        .valid        (valid),
        .set          (set),
        .precision    (precision),
        .sign_out     (sign_out),
        .exp_out      (exp_out),
        .mantissa_out (mantissa_out),
        .start_acc    (start_acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        int          p;
        logic [3:0]  wb;
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
    } vec_t;

    exp_t sbq[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;
    int   npulse = 0;
    int   cur_p = 4;

    task automatic check(input string name, input int act_v, input int req_v);
        total++;
        if (act_v != req_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act_v, req_v);
        end
    endtask

    // Scoreboard: each start_acc pops one expected product.
    always @(negedge clk) begin
        if (!rst && start_acc) begin
            exp_t ex;
            npulse++;
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_start_acc: got s=%0d e=%0h m=%0h want no pulse",
                         sign_out, exp_out, mantissa_out);
            end else begin
                ex = sbq.pop_front();
                if ({sign_out, exp_out, mantissa_out} !== {ex.s, ex.e, ex.m}) begin
                    bad++;
                    $display("FAIL product: got s=%0d e=%0h m=%0h want s=%0d e=%0h m=%0h",
                             sign_out, exp_out, mantissa_out, ex.s, ex.e, ex.m);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic [15:0] a, input logic b);
        act   = a;
        w     = b;
        valid = 1'b1;
        set   = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        set   = 1'b0;
        w     = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_set(input logic [3:0] p, input logic v);
        precision = p;
        set       = 1'b1;
        valid     = v;
        w         = 1'b1;
        tick();
        set       = 1'b0;
    endtask

    task automatic push(input logic s, input logic [4:0] e, input logic [13:0] m);
        exp_t ex;
        ex.s = s; ex.e = e; ex.m = m;
        sbq.push_back(ex);
        last_exp = ex;
    endtask

    task automatic send_weight(input logic [15:0] a, input int p, input logic [3:0] wb,
                               input logic s, input logic [4:0] e, input logic [13:0] m);
        for (int k = 0; k < p; k++) begin
            if (k == p - 1) push(s, e, m);
            send_bit(a, wb[k]);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input int p, input logic [3:0] wb);
        exp_t r;
        int   sig, wv, prod;
        logic [4:0] e;
        logic [9:0] f;
        e   = a[14:10];
        f   = a[9:0];
        sig = (e == 5'd0) ? int'(f) : int'(f) + 1024;
        wv  = 0;
        for (int k = 0; k < p; k++)
            if (wb[k]) wv += (k == p - 1) ? -(1 << k) : (1 << k);
        prod = sig * wv;
        r.s  = a[15] ^ wb[p-1];
        r.e  = e;
        r.m  = 14'((prod < 0) ? -prod : prod);
        return r;
    endfunction

    vec_t tbl[9];

    initial begin
        int   p0;
        exp_t ex;
        tbl[0] = '{16'h1234, 4, 4'b0101, 1'b0, 5'b00100, 14'h1F04};
        tbl[1] = '{16'hF234, 4, 4'b1101, 1'b0, 5'b11100, 14'h129C};
        tbl[2] = '{16'hF234, 4, 4'b0000, 1'b1, 5'b11100, 14'h0000};
        tbl[3] = '{16'h3C00, 4, 4'b1000, 1'b1, 5'b01111, 14'h2000};
        tbl[4] = '{16'hFBFF, 4, 4'b1000, 1'b0, 5'b11110, 14'h3FF8};
        tbl[5] = '{16'h7BFF, 3, 4'b0011, 1'b0, 5'b11110, 14'h17FD};
        tbl[6] = '{16'h0001, 1, 4'b0001, 1'b1, 5'b00000, 14'h0001};
        tbl[7] = '{16'h0000, 2, 4'b0001, 1'b0, 5'b00000, 14'h0000};
        tbl[8] = '{16'h8400, 2, 4'b0011, 1'b0, 5'b00001, 14'h0400};

        rst = 1'b1; act = '0; w = 1'b0; valid = 1'b0; set = 1'b0; precision = 4'd4;
        repeat (3) tick();
        check("reset_sign", int'(sign_out), 0);
        check("reset_exp", int'(exp_out), 0);
        check("reset_mant", int'(mantissa_out), 0);
        check("reset_start", int'(start_acc), 0);
        rst = 1'b0;
        tick();

        // Table vectors, back-to-back where precision does not change
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].p != cur_p) begin
                do_set(4'(tbl[i].p), 1'b0);
                cur_p = tbl[i].p;
            end
            send_weight(tbl[i].a, tbl[i].p, tbl[i].wb, tbl[i].s, tbl[i].e, tbl[i].m);
        end
        idle(2);

        // Abort: two of four bits then valid low; nothing must change
        do_set(4'd4, 1'b0);
        cur_p = 4;
        p0 = npulse;
        send_bit(16'h3C00, 1'b1);
        send_bit(16'h3C00, 1'b1);
        idle(2);
        check("abort_no_pulse", npulse - p0, 0);
        check("abort_hold", int'({sign_out, exp_out, mantissa_out}),
              int'({last_exp.s, last_exp.e, last_exp.m}));
        send_weight(16'h1234, 4, 4'b0101, 1'b0, 5'b00100, 14'h1F04);
        idle(1);

        // Set with valid high mid-weight aborts and that bit is dropped
        p0 = npulse;
        send_bit(16'h3C00, 1'b1);
        do_set(4'd4, 1'b1);
        check("set_abort_no_pulse", npulse - p0, 0);
        send_weight(16'hF234, 4, 4'b1101, 1'b0, 5'b11100, 14'h129C);
        idle(1);

        // Illegal precision stores as 4
        do_set(4'd9, 1'b0);
        send_weight(16'h3C00, 4, 4'b1000, 1'b1, 5'b01111, 14'h2000);
        idle(1);

        // Streaming at P=2: pulse every 2 cycles
        do_set(4'd2, 1'b0);
        cur_p = 2;
        p0 = npulse;
        for (int k = 0; k < 3; k++)
            send_weight(16'h3C00, 2, 4'b0011, 1'b1, 5'b01111, 14'h0400);
        idle(1);
        check("stream_pulses", npulse - p0, 3);

        // Reset mid-weight: outputs clear, precision back to 4
        send_bit(16'h3C00, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        check("rst_mid_sign", int'(sign_out), 0);
        check("rst_mid_exp", int'(exp_out), 0);
        check("rst_mid_mant", int'(mantissa_out), 0);
        check("rst_mid_start", int'(start_acc), 0);
        rst = 1'b0;
        idle(1);
        cur_p = 4;
        p0 = npulse;
        send_weight(16'h3C00, 4, 4'b1000, 1'b1, 5'b01111, 14'h2000);
        idle(2);
        check("rst_prec4_pulses", npulse - p0, 1);

        // Random sweep against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [3:0]  wb;
            int          p;
            a  = 16'($urandom);
            wb = 4'($urandom);
            p  = $urandom_range(1, 4);
            if (p != cur_p) begin
                do_set(4'(p), 1'b0);
                cur_p = p;
            end
            ex = model(a, p, wb);
            send_weight(a, p, wb, ex.s, ex.e, ex.m);
        end

        // Drain with a bounded wait
        idle(4);
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
